scalar_result_wb: RTL

Returns vector-unit results to the scalar side: the writeback path for vmv.x.s and vfmv.f.s. It runs in the opposite direction to the operand-A path, which feeds scalar or immediate values into the vector ALU. The block captures a 64-bit element result, narrows it to the active SEW, and extends it to 64 bits. It buffers the result in a small FIFO and hands it to the scalar register-file write port over a valid/ready handshake.

---
 rtl/scalar_result_wb.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/scalar_result_wb.sv
// -----------------------------------------------------------------------------
// scalar_result_wb
//   Writeback path from the vector unit to the scalar register file
//   (vmv.x.s / vfmv.f.s). Each accepted element is narrowed to the active
//   SEW and extended back to 64 bits. The extended value is queued in a
//   small circular FIFO and presented to the scalar write port over a
//   valid/ready handshake.
//
//   Optional feature macro: SCALAR_WB_NANBOX_EN
//     defined   : FP destinations with SEW < 64 are NaN-boxed (upper bits = 1)
//     undefined : integer sign/zero extension for every element
//
// Parameters
//   DEPTH     FIFO entries; power of two, >= 2
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   flush               synchronous flush; empties the FIFO
//   in_valid/in_ready   producer handshake (in_ready = !full && !flush)
//   in_data[63:0]       raw element; low SEW bits significant
//   in_sew[1:0]         00=8, 01=16, 10=32, 11=64
//   in_zext             1 = zero-extend, 0 = sign-extend
//   in_is_fp            FP destination
//   in_rd[4:0]          destination register index
//   wb_valid/wb_ready   consumer handshake
//   wb_data[63:0]       extended result of head entry (0 while empty)
//   wb_rd[4:0]          destination index of head entry
//   wb_is_fp            FP register-file select of head entry
//   count               occupancy
// -----------------------------------------------------------------------------
module scalar_result_wb #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [63:0]                in_data,
  input  logic [1:0]                 in_sew,
  input  logic                       in_zext,
  input  logic                       in_is_fp,
  input  logic [4:0]                 in_rd,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [63:0]                wb_data,
  output logic [4:0]                 wb_rd,
  output logic                       wb_is_fp,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        is_fp;
  } entry_t;

  // State
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];

  logic   full, empty, push, pop;
  logic   fill;
  logic [63:0] ext_data;
  entry_t new_entry;
  entry_t head;

  // ---------------------------------------------------------------------------
  // Narrow + extend at push time so the FIFO holds final values.
  // ---------------------------------------------------------------------------
  always_comb begin
    fill     = 1'b0;
    ext_data = in_data;
    unique case (in_sew)
      2'b00:   fill = in_zext ? 1'b0 : in_data[7];
      2'b01:   fill = in_zext ? 1'b0 : in_data[15];
      2'b10:   fill = in_zext ? 1'b0 : in_data[31];
      default: fill = 1'b0;
    endcase
`ifdef SCALAR_WB_NANBOX_EN
    // NaN-boxing overrides zext for narrow FP results.
    if (in_is_fp && in_sew != 2'b11) fill = 1'b1;
`endif
    unique case (in_sew)
      2'b00:   ext_data = {{56{fill}}, in_data[7:0]};
      2'b01:   ext_data = {{48{fill}}, in_data[15:0]};
      2'b10:   ext_data = {{32{fill}}, in_data[31:0]};
      default: ext_data = in_data;
    endcase
    new_entry.data  = ext_data;
    new_entry.rd    = in_rd;
    new_entry.is_fp = in_is_fp;
  end

  // ---------------------------------------------------------------------------
  // Handshakes. in_ready looks only at count and flush, so there is no
  // combinational path from wb_ready back to the producer.
  // ---------------------------------------------------------------------------
  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    in_ready = !full && !flush;
    wb_valid = !empty;
    push     = in_valid && in_ready;
    pop      = wb_valid && wb_ready;
  end

  // ---------------------------------------------------------------------------
  // Next-state: pointers, count, storage. Flush wins over push and pop; a
  // pop coinciding with flush is simply absorbed by the clear.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1; // wraps modulo DEPTH (power of two)
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: outputs are masked while empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  // ---------------------------------------------------------------------------
  // Head-entry outputs. Held stable during a stall because the read pointer
  // only moves on a pop and the head slot is never written while occupied.
  // ---------------------------------------------------------------------------
  always_comb begin
    head     = mem_q[rd_ptr_q];
    wb_data  = wb_valid ? head.data  : 64'd0;
    wb_rd    = wb_valid ? head.rd    : 5'd0;
    wb_is_fp = wb_valid ? head.is_fp : 1'b0;
    count    = count_q;
  end

endmodule
